// File: rtl/vecrf_pkg.sv
// vecrf_pkg: shared vector register file constants and types
package vecrf_pkg;
  localparam int VRF_NREGS = 16;
  localparam int VRF_LANES = 4;
  localparam int VRF_DW = 32;
  localparam int VRF_AW = $clog2(VRF_NREGS);
  typedef logic [VRF_LANES-1:0][VRF_DW-1:0] vreg_t;
  typedef logic [VRF_AW-1:0] vaddr_t;
endpackage

// File: rtl/vecrf_wr_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter, last_grant resets to 1 so requester 0 wins the first tie
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic last_grant;
  // grant the lone requester, or on a tie the one not served last; nothing during reset
  always_comb grant = rst ? 2'b00 : (&valid) ? (last_grant ? 2'b01 : 2'b10) : valid;
  // remember who was served; a grant always implies an accepted transfer
  always_ff @(posedge clk)
    if (rst) last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[1];
endmodule

// File: rtl/vecrf_wr_arbiter.sv
// vecrf_wr_arbiter: round-robin write-port arbiter with optional pending-write scoreboard (VECRF_SCOREBOARD_EN)
module vecrf_wr_arbiter
  import vecrf_pkg::*;
#(
  parameter int NREGS = VRF_NREGS,
  parameter int LANES = VRF_LANES,
  parameter int DW = VRF_DW,
  parameter int AW = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [AW-1:0]             req0_addr,
  input  logic [LANES-1:0][DW-1:0]  req0_data,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [AW-1:0]             req1_addr,
  input  logic [LANES-1:0][DW-1:0]  req1_data,
  output logic                      wren,
  output logic [AW-1:0]             wraddr,
  output logic [LANES-1:0][DW-1:0]  wrdata,
  input  logic                      rsv_valid,
  input  logic [AW-1:0]             rsv_addr,
  output logic [NREGS-1:0]          busy
);
  logic [1:0] grant;
  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  // single write stage; address and data hold when nothing is accepted
  always_ff @(posedge clk)
    if (rst) begin
      wren <= 1'b0;
      wraddr <= '0;
      wrdata <= '0;
    end else begin
      wren <= |grant;
      if (|grant) begin
        wraddr <= grant[1] ? req1_addr : req0_addr;
        wrdata <= grant[1] ? req1_data : req0_data;
      end
    end
`ifdef VECRF_SCOREBOARD_EN
  logic [NREGS-1:0] sb_set, sb_clr;
  always_comb sb_set = rsv_valid ? NREGS'(1) << rsv_addr : '0;
  always_comb sb_clr = wren ? NREGS'(1) << wraddr : '0;
  // clear the written register, then set the reserved one so a same-cycle set wins
  always_ff @(posedge clk)
    if (rst) busy <= '0;
    else busy <= (busy & ~sb_clr) | sb_set;
  ap_rsv_not_busy: assert property (@(posedge clk) disable iff (rst)
    rsv_valid && !(wren && wraddr == rsv_addr) |-> !busy[rsv_addr]);
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsv_valid, rsv_addr};
  assign busy = '0;
`endif
endmodule

// File: tb/tb_vecrf_wr_arbiter.sv
// tb_vecrf_wr_arbiter: directed self-checking bench for vecrf_wr_arbiter
module tb_vecrf_wr_arbiter;
`ifdef VECRF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [3:0] req0_addr = 0, req1_addr = 0, wraddr, rsv_addr = 0;
  logic [3:0][31:0] req0_data = '0, req1_data = '0, wrdata;
  logic wren, rsv_valid = 0;
  logic [15:0] busy;
  logic [127:0] rf [16];
  int total = 0, bad = 0;
  localparam logic [127:0] D1 = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
  localparam logic [127:0] DA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] DB = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
  vecrf_wr_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (wren) rf[wraddr] <= wrdata;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    step();
    req0_valid = 1; req1_valid = 1; rsv_valid = 1; rsv_addr = 1;
    #1;
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    step();
    req0_valid = 0; req1_valid = 0; rsv_valid = 0;
    chk("rst_wren", wren, 0);
    chk("rst_wraddr", wraddr, 0);
    chk("rst_wrdata", wrdata, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    req0_valid = 1; req0_addr = 3; req0_data = D1;
    #1;
    chk("t1_rdy0", req0_ready, 1);
    chk("t1_rdy1", req1_ready, 0);
    step();
    req0_valid = 0;
    chk("t1_wren", wren, 1);
    chk("t1_wraddr", wraddr, 3);
    chk("t1_wrdata", wrdata, D1);
    step();
    chk("t1_idle", wren, 0);
    chk("t1_hold_addr", wraddr, 3);
    chk("t1_hold_data", wrdata, D1);
    chk("t1_rf3", rf[3], D1);
    req1_valid = 1; req1_addr = 9; req1_data = DB;
    #1;
    chk("t2_pre_rdy1", req1_ready, 1);
    step();
    req1_valid = 0;
    chk("t2_pre_wraddr", wraddr, 9);
    step();
    req0_valid = 1; req0_addr = 1; req0_data = DA;
    req1_valid = 1; req1_addr = 2; req1_data = DB;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_rdy0", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("t2_rdy1", req1_ready, (i % 2 == 0) ? 0 : 1);
      step();
      chk("t2_wren", wren, 1);
      chk("t2_wraddr", wraddr, (i % 2 == 0) ? 1 : 2);
    end
    req0_valid = 0; req1_valid = 0;
    step();
    req0_valid = 1; req0_addr = 5; req0_data = DA;
    req1_valid = 1; req1_addr = 5; req1_data = DB;
    #1;
    chk("t3_rdy0", req0_ready, 1);
    step();
    chk("t3_w1_data", wrdata, DA);
    chk("t3_w1_addr", wraddr, 5);
    req0_valid = 0;
    #1;
    chk("t3_rdy1", req1_ready, 1);
    step();
    req1_valid = 0;
    chk("t3_w2_wren", wren, 1);
    chk("t3_w2_data", wrdata, DB);
    step();
    chk("t3_rf5", rf[5], DB);
    rsv_valid = 1; rsv_addr = 7;
    step();
    rsv_valid = 0;
    chk("t4_set", busy, SB ? 16'h0080 : 16'h0000);
    req1_valid = 1; req1_addr = 7; req1_data = DA;
    #1;
    chk("t4_rdy1", req1_ready, 1);
    step();
    req1_valid = 0;
    chk("t4_wren", wren, 1);
    chk("t4_busy_wren", busy, SB ? 16'h0080 : 16'h0000);
    step();
    chk("t4_clr", busy, 0);
    rsv_valid = 1; rsv_addr = 7;
    step();
    rsv_valid = 0;
    chk("t4_set2", busy, SB ? 16'h0080 : 16'h0000);
    req0_valid = 1; req0_addr = 7; req0_data = DB;
    step();
    req0_valid = 0;
    rsv_valid = 1; rsv_addr = 7;
    chk("t4_wren2_addr", wraddr, 7);
    step();
    rsv_valid = 0;
    chk("t4_set_wins", busy, SB ? 16'h0080 : 16'h0000);
    for (int a = 4; a < 7; a++) begin
      rsv_valid = 1; rsv_addr = 4'(a);
      step();
    end
    rsv_valid = 0;
    chk("t5_busy_f0", busy, SB ? 16'h00F0 : 16'h0000);
    req0_valid = 1; req0_addr = 4'hA; req0_data = D1;
    #1;
    chk("t5_rdy0", req0_ready, 1);
    rst = 1; req1_valid = 1; req1_addr = 4'hB; rsv_valid = 1; rsv_addr = 3;
    #1;
    chk("t5_rst_rdy0", req0_ready, 0);
    chk("t5_rst_rdy1", req1_ready, 0);
    step();
    chk("t5_rst_wren", wren, 0);
    chk("t5_rst_busy", busy, 0);
    rst = 0; rsv_valid = 0;
    #1;
    chk("t5_tie_rdy0", req0_ready, 1);
    chk("t5_tie_rdy1", req1_ready, 0);
    step();
    req0_valid = 0; req1_valid = 0;
    chk("t5_tie_wren", wren, 1);
    chk("t5_tie_wraddr", wraddr, 4'hA);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vecrf_wr_arbiter.md
# vecrf_wr_arbiter

Write-port controller for the vector register file: 16 registers × 4 lanes × 32 bits, two read ports, one write port (`wren`/`wraddr`/`wrdata`). Two producers share the single write port: requester 0 is the vector ALU writeback and requester 1 is the vector load unit. The block arbitrates between them round-robin and drives the register file write port through one register stage. It also keeps a per-register pending-write scoreboard, which the issue stage uses for RAW/WAW hazard stalls.

## Interface
Parameters:
- `NREGS`, 16, number of vector registers
- `LANES`, 4, 32-bit lanes per vector
- `DW`, 32, lane width
- `AW`, `$clog2(NREGS)` = 4, register address width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0_valid`  in  1  ALU write request
- `req0_ready`  out  1  ALU request accepted this cycle
- `req0_addr`  in  AW  destination register
- `req0_data`  in  LANES×DW  vector data, lane 0 in the low word
- `req1_valid` / `req1_ready` / `req1_addr` / `req1_data`  same as requester 0, for the load unit
- `wren`  out  1  register-file write enable
- `wraddr`  out  AW  register-file write address
- `wrdata`  out  LANES×DW  register-file write data
- `rsv_valid`  in  1  issue stage reserves a destination register
- `rsv_addr`  in  AW  register being reserved
- `busy`  out  NREGS  pending-write bit per register

## Operation
- Handshake: a transfer happens when `reqN_valid && reqN_ready`. A requester holds valid, addr and data stable until it is accepted. Ready never depends on ready.
- Grant is combinational from the valids and `last_grant`:
  - only one requester valid → that requester is granted;
  - both valid → the requester ≠ `last_grant` is granted;
  - none valid → no grant.
- `reqN_ready` = grant N. `last_grant` updates only on an accepted transfer.
- Accepted transfer in cycle N → `wren`=1 with the granted addr/data in cycle N+1. No accept → `wren`=0; `wraddr`/`wrdata` hold their last values.
- Both requesters on the same address: served in two consecutive cycles in round-robin order. The later write wins in the register file.
- Scoreboard, updated at the clock edge:
  - `busy[rsv_addr]` is set when `rsv_valid`;
  - `busy[wraddr]` is cleared when `wren`;
  - set and clear on the same register in the same cycle → set wins.
- Reserving a register that is already busy is illegal. Simulation asserts on it; in RTL the bit simply stays 1.

## Timing
- Reset values: `wren`=0, `wraddr`=0, `wrdata`=0, `busy`=0, `last_grant`=1 (so requester 0 wins the first tie).
- While `rst`=1: both readies are 0 and all reservations are ignored.
- Reset mid-operation: in-flight and pending writes are dropped, and all busy bits are cleared in the next cycle.
- Latency: accept → `wren` is 1 cycle. The register-file update lands at the end of the `wren` cycle. The data is readable on the read ports in accept+2.
- `busy[a]` drops in the cycle after the `wren` cycle, i.e. accept+2. This matches read-after-write visibility.
- Throughput: one write per cycle. Under continuous contention each requester gets every other cycle.

## Configuration
- `VECRF_SCOREBOARD_EN` defined: scoreboard built as described.
- Undefined: no scoreboard flops; `busy` tied to 0; `rsv_valid`/`rsv_addr` ignored. Arbitration and write timing are unchanged.

## Structure
- Package `vecrf_pkg` holds:
  - constants `VRF_NREGS`, `VRF_LANES`, `VRF_DW`, `VRF_AW`;
  - typedef `vreg_t` = `logic [VRF_LANES-1:0][VRF_DW-1:0]`;
  - typedef `vaddr_t` = `logic [VRF_AW-1:0]`.
- Sub-module `rr_arb2`: two-input round-robin arbiter holding the `last_grant` state.
- Write-stage registers and the scoreboard live in the top level.

## Test plan
- After reset, only `req0` valid, addr 3, data {4444,3333,2222,1111} → `req0_ready`=1 in that cycle; next cycle `wren`=1, `wraddr`=3, `wrdata` matches; the register-file read of reg 3 returns the data at accept+2.
- Both valid continuously for 4 cycles (req0 addr 1, req1 addr 2) → grants 0,1,0,1; `wraddr` sequence 1,2,1,2, each one cycle after its grant.
- Both valid, same addr 5 (req0 data A, req1 data B) → two writes in consecutive cycles; reg 5 ends up holding whichever was granted second.
- `rsv_valid` addr 7 → `busy[7]`=1 next cycle; a later req1 write to 7 → `busy[7]`=0 at accept+2. A reservation of 7 coinciding with the `wren` cycle of a write to 7 → `busy[7]` stays 1.
- Assert `rst` while `req0` is granted and `busy`=0x00F0 → next cycle `wren`=0, `busy`=0, readies 0 during reset; after release, a tie grants requester 0.
- Build without `VECRF_SCOREBOARD_EN`: `rsv_valid` on addr 2 → `busy` remains 0; write timing is identical to the first scenario.
